// File: rtl/gate_engine_2q_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// gate_engine_2q_pkg : opcodes, Q7.8 constants, FSM states, sat16 (rev 1.0)
// ---------------------------------------------------------------
package gate_engine_2q_pkg;

  localparam logic [2:0] OP_INIT = 3'd0;
  localparam logic [2:0] OP_X    = 3'd1;
  localparam logic [2:0] OP_Z    = 3'd2;
  localparam logic [2:0] OP_H    = 3'd3;
  localparam logic [2:0] OP_S    = 3'd4;
  localparam logic [2:0] OP_CNOT = 3'd5;

  localparam logic signed [15:0] AMP_ONE = 16'sd256;
  localparam logic signed [8:0]  H_COEF  = 9'sd181;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [24:0] x);
    if (x > 25'sd32767)
      return 16'sh7fff;
    else if (x < -25'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_engine_2q_alu.sv
`default_nettype none
// ---------------------------------------------------------------
// gate_pair_alu : combinational single-gate update of one amplitude pair (rev 1.0)
// ---------------------------------------------------------------
module gate_pair_alu
  import gate_engine_2q_pkg::*;
(
  input  logic [2:0]         op,
  input  logic               phase,
  input  logic signed [15:0] a_re,
  input  logic signed [15:0] a_im,
  input  logic signed [15:0] b_re,
  input  logic signed [15:0] b_im,
  output logic signed [15:0] a_re_new,
  output logic signed [15:0] a_im_new,
  output logic signed [15:0] b_re_new,
  output logic signed [15:0] b_im_new
);

  // Sum/difference fits 17 bits and the product 25 bits, so no overflow before the clamp.
  function automatic logic signed [15:0] h_mix(input logic signed [15:0] x,
                                               input logic signed [15:0] y,
                                               input logic               sub);
    logic signed [24:0] s;
    s = sub ? (25'(x) - 25'(y)) : (25'(x) + 25'(y));
    return sat16((s * 25'(H_COEF)) >>> 8);
  endfunction

  function automatic logic signed [15:0] neg(input logic signed [15:0] x);
    return sat16(-25'(x));
  endfunction

  always_comb begin
    a_re_new = a_re;
    a_im_new = a_im;
    b_re_new = b_re;
    b_im_new = b_im;
    case (op)
      OP_X: begin
        a_re_new = b_re;
        a_im_new = b_im;
        b_re_new = a_re;
        b_im_new = a_im;
      end
      OP_Z: begin
        b_re_new = neg(b_re);
        b_im_new = neg(b_im);
      end
      OP_S: begin
        b_re_new = neg(b_im);
        b_im_new = b_re;
      end
      OP_H: begin
        a_re_new = h_mix(a_re, b_re, 1'b0);
        a_im_new = h_mix(a_im, b_im, 1'b0);
        b_re_new = h_mix(a_re, b_re, 1'b1);
        b_im_new = h_mix(a_im, b_im, 1'b1);
      end
      OP_CNOT: begin
        if (phase) begin
          a_re_new = b_re;
          a_im_new = b_im;
          b_re_new = a_re;
          b_im_new = a_im;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gate_engine_2q.sv
`default_nettype none
// ---------------------------------------------------------------
// gate_engine_2q : 2-qubit state vector, one gate per command over two pair phases (rev 1.0)
// ---------------------------------------------------------------
module gate_engine_2q
  import gate_engine_2q_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic               cmd_q,
  output logic signed [15:0] amp00_real,
  output logic signed [15:0] amp00_imag,
  output logic signed [15:0] amp01_real,
  output logic signed [15:0] amp01_imag,
  output logic signed [15:0] amp10_real,
  output logic signed [15:0] amp10_imag,
  output logic signed [15:0] amp11_real,
  output logic signed [15:0] amp11_imag,
  output logic               state_valid,
  output logic               done,
  output logic               err
);

  state_t             state, state_next;
  logic [2:0]         op;
  logic               q;
  logic               phase;
  logic [1:0]         idx_a, idx_b;
  logic signed [15:0] re [4];
  logic signed [15:0] im [4];
  logic signed [15:0] a_re_new, a_im_new, b_re_new, b_im_new;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = P0;
      P0:      state_next = P1;
      P1:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready   = (state == IDLE);
  assign state_valid = cmd_ready;
  assign phase       = (state == P1);

  // Element a has the target bit clear, b has it set; phase picks the other bit.
  always_comb begin
    if (q) begin
      idx_a = {1'b0, phase};
      idx_b = {1'b1, phase};
    end else begin
      idx_a = {phase, 1'b0};
      idx_b = {phase, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op   <= OP_INIT;
      q    <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        op <= cmd_op;
        q  <= cmd_q;
      end
      done <= (state == P1);
      err  <= (state == P1) && (op > OP_CNOT);
    end
  end

  gate_pair_alu u_alu (
    .op       (op),
    .phase    (phase),
    .a_re     (re[idx_a]),
    .a_im     (im[idx_a]),
    .b_re     (re[idx_b]),
    .b_im     (im[idx_b]),
    .a_re_new (a_re_new),
    .a_im_new (a_im_new),
    .b_re_new (b_re_new),
    .b_im_new (b_im_new)
  );

  // Reserved opcodes pass through the ALU unchanged, so their writes are no-ops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        re[i] <= (i == 0) ? AMP_ONE : 16'sd0;
        im[i] <= 16'sd0;
      end
    end else if (state == P0 && op == OP_INIT) begin
      for (int i = 0; i < 4; i++) begin
        re[i] <= (i == 0) ? AMP_ONE : 16'sd0;
        im[i] <= 16'sd0;
      end
    end else if (state != IDLE && op != OP_INIT) begin
      re[idx_a] <= a_re_new;
      im[idx_a] <= a_im_new;
      re[idx_b] <= b_re_new;
      im[idx_b] <= b_im_new;
    end
  end

  assign amp00_real = re[0];
  assign amp00_imag = im[0];
  assign amp01_real = re[1];
  assign amp01_imag = im[1];
  assign amp10_real = re[2];
  assign amp10_imag = im[2];
  assign amp11_real = re[3];
  assign amp11_imag = im[3];

endmodule
`default_nettype wire

// File: tb/tb_gate_engine_2q.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_gate_engine_2q : scoreboard bench for gate_engine_2q (rev 1.0)
// ---------------------------------------------------------------
module tb_gate_engine_2q;

  localparam logic [2:0] C_INIT = 3'd0, C_X = 3'd1, C_Z = 3'd2, C_H = 3'd3,
                         C_S = 3'd4, C_CNOT = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic cmd_q = 1'b0;
  logic cmd_ready, state_valid, done, err;
  logic signed [15:0] a00r, a00i, a01r, a01i, a10r, a10i, a11r, a11i;

  logic [2:0] t_op = 3'd0;
  logic t_phase = 1'b0;
  logic signed [15:0] t_are = '0, t_aim = '0, t_bre = '0, t_bim = '0;
  logic signed [15:0] t_are_n, t_aim_n, t_bre_n, t_bim_n;

  always #5 clk = ~clk;

  gate_engine_2q dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_q(cmd_q),
    .amp00_real(a00r), .amp00_imag(a00i), .amp01_real(a01r), .amp01_imag(a01i),
    .amp10_real(a10r), .amp10_imag(a10i), .amp11_real(a11r), .amp11_imag(a11i),
    .state_valid(state_valid), .done(done), .err(err)
  );

  gate_pair_alu u_alu (
    .op(t_op), .phase(t_phase), .a_re(t_are), .a_im(t_aim), .b_re(t_bre), .b_im(t_bim),
    .a_re_new(t_are_n), .a_im_new(t_aim_n), .b_re_new(t_bre_n), .b_im_new(t_bim_n)
  );

  typedef struct {
    string            name;
    logic             err;
    logic [7:0][15:0] amp;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [7:0][15:0] act;
  assign act = {a11i, a11r, a10i, a10r, a01i, a01r, a00i, a00r};

  function automatic logic [7:0][15:0] st(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [7:0][15:0] r;
    r[0] = v0[15:0]; r[1] = v1[15:0]; r[2] = v2[15:0]; r[3] = v3[15:0];
    r[4] = v4[15:0]; r[5] = v5[15:0]; r[6] = v6[15:0]; r[7] = v7[15:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending command");
      end else begin
        e = exp_q.pop_front();
        chk(e.name, act, e.amp);
        chk({e.name, "_err"}, {127'd0, err}, {127'd0, e.err});
      end
    end else if (err) begin
      checks++;
      failures++;
      $display("FAIL err_without_done: got err=1 done=0 expected err=0");
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic q, input string name,
                       input logic [7:0][15:0] amp, input logic e_err);
    exp_t e;
    wait_ready();
    e.name = name; e.err = e_err; e.amp = amp;
    exp_q.push_back(e);
    cmd_op = op; cmd_q = q; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  logic [7:0][15:0] ONE;

  initial begin
    int low, done_at, n;
    exp_t e;
    ONE = st(256, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_amps", act, ONE);
    chk("reset_ready", {126'd0, cmd_ready, state_valid}, 128'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_done_err", {126'd0, done, err}, 128'd0);

    // Latency and ready timing of the first command
    issue(C_H, 1'b0, "h_q0", st(181, 0, 181, 0, 0, 0, 0, 0), 1'b0);
    low = 0; done_at = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (!cmd_ready) low++;
      if (done && done_at == 0) done_at = i;
    end
    chk("ready_low_cycles", 128'(low), 128'd2);
    chk("done_latency", 128'(done_at), 128'd3);

    // H twice: 362*181>>8 = 255, difference vanishes
    issue(C_INIT, 1'b0, "init_a", ONE, 1'b0);
    issue(C_H, 1'b0, "hh_1", st(181, 0, 181, 0, 0, 0, 0, 0), 1'b0);
    issue(C_H, 1'b0, "hh_2", st(255, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Bell pair
    issue(C_INIT, 1'b0, "init_b", ONE, 1'b0);
    issue(C_H, 1'b1, "bell_h", st(181, 0, 0, 0, 181, 0, 0, 0), 1'b0);
    issue(C_CNOT, 1'b0, "bell_cnot", st(181, 0, 0, 0, 0, 0, 181, 0), 1'b0);

    // Phase gates, truncation toward -inf, imag-part paths
    issue(C_INIT, 1'b0, "init_c", ONE, 1'b0);
    issue(C_X, 1'b1, "x_q1", st(0, 0, 0, 0, 256, 0, 0, 0), 1'b0);
    issue(C_S, 1'b1, "s_q1_a", st(0, 0, 0, 0, 0, 256, 0, 0), 1'b0);
    issue(C_S, 1'b1, "s_q1_b", st(0, 0, 0, 0, -256, 0, 0, 0), 1'b0);
    issue(C_Z, 1'b1, "z_q1", st(0, 0, 0, 0, 256, 0, 0, 0), 1'b0);
    issue(C_X, 1'b0, "x_q0", st(0, 0, 0, 0, 0, 0, 256, 0), 1'b0);
    issue(C_Z, 1'b0, "z_q0", st(0, 0, 0, 0, 0, 0, -256, 0), 1'b0);
    issue(C_H, 1'b1, "h_q1_neg", st(0, 0, -181, 0, 0, 0, 181, 0), 1'b0);
    issue(C_H, 1'b0, "h_q0_trunc", st(-128, 0, 127, 0, 127, 0, -128, 0), 1'b0);
    issue(C_S, 1'b0, "s_q0", st(-128, 0, 0, 127, 127, 0, 0, -128), 1'b0);
    issue(C_CNOT, 1'b1, "cnot_q1", st(-128, 0, 0, -128, 127, 0, 0, 127), 1'b0);
    issue(C_X, 1'b1, "x_q1_imag", st(127, 0, 0, 127, -128, 0, 0, -128), 1'b0);

    // Reserved opcodes leave the state alone and flag err
    issue(3'd6, 1'b0, "rsv6", st(127, 0, 0, 127, -128, 0, 0, -128), 1'b1);
    issue(3'd7, 1'b1, "rsv7", st(127, 0, 0, 127, -128, 0, 0, -128), 1'b1);

    // cmd_valid held through busy: accepted at k and again at k+3 only
    issue(C_INIT, 1'b0, "init_d", ONE, 1'b0);
    wait_ready();
    e.name = "held_x1"; e.err = 1'b0; e.amp = st(0, 0, 256, 0, 0, 0, 0, 0);
    exp_q.push_back(e);
    e.name = "held_x2"; e.amp = ONE;
    exp_q.push_back(e);
    cmd_op = C_X; cmd_q = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;

    // Reset during P1 of an H: state reloads, no done
    issue(C_X, 1'b0, "x_pre_rst", st(0, 0, 256, 0, 0, 0, 0, 0), 1'b0);
    wait_ready();
    cmd_op = C_H; cmd_q = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("midcmd_rst_amps", act, ONE);
    chk("midcmd_rst_ready", {127'd0, cmd_ready}, 128'd1);
    repeat (2) @(negedge clk);
    chk("midcmd_rst_done", {126'd0, done, err}, 128'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {126'd0, cmd_ready, done}, 128'd2);
    issue(C_H, 1'b0, "h_after_rst", st(181, 0, 181, 0, 0, 0, 0, 0), 1'b0);

    // Drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    // Saturation corners on the pair ALU
    t_op = C_H; t_phase = 1'b0;
    t_are = 16'sh7fff; t_aim = 16'sh8000; t_bre = 16'sh7fff; t_bim = 16'sh8000;
    #1 chk("sat_h", {64'd0, t_are_n, t_aim_n, t_bre_n, t_bim_n},
           {64'd0, 16'h7fff, 16'h8000, 16'h0000, 16'h0000});
    t_op = C_Z; t_are = 16'sd3; t_aim = 16'sd4; t_bre = 16'sh8000; t_bim = 16'sd100;
    #1 chk("sat_z", {64'd0, t_are_n, t_aim_n, t_bre_n, t_bim_n},
           {64'd0, 16'h0003, 16'h0004, 16'h7fff, 16'hff9c});
    t_op = C_S; t_bre = 16'sd5; t_bim = 16'sh8000;
    #1 chk("sat_s", {64'd0, t_are_n, t_aim_n, t_bre_n, t_bim_n},
           {64'd0, 16'h0003, 16'h0004, 16'h7fff, 16'h0005});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
